mbc_rtc_save_reader: RTL and testbench
======================================

Name: mbc_rtc_save_reader

Overview:
- Read-side counterpart of the MBC3 RTC save-file load path.
- The load path accepts bk_rtc_wr words 0..4 and commits them on word 4. This block serves the same 5-word layout back to the HPS when the savegame is written out.
- It takes an atomic snapshot of the running RTC timestamp and RTC state, answers bk_rtc_rd reads with a fixed one-cycle latency, and raises a periodic autosave request while the RTC is in use.
- It sits beside the mapper in the cart top level, fed by the mapper's RTC_timestampOut, RTC_savedtimeOut and RTC_inuse.

Parameters:
- SAVE_INTERVAL, 300, seconds of RTC advance (timestamp +1 steps) after which rtc_save_due asserts.
- CNT_W, 16, width of the interval counter; must satisfy SAVE_INTERVAL < 2^CNT_W.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  the mapper using this block is active; when low, reads are acked with 16'hFFFF and rtc_save_due is held 0.
- RTC_inuse  in  1  the RTC is used by the game or the savegame.
- RTC_timestampOut  in  32  running Unix-second timestamp from the mapper.
- RTC_savedtimeOut  in  32  packed RTC state {3'd0, halt, overflow, days[9:0], hours[4:0], min[5:0], sec[5:0]}.
- bk_rtc_rd  in  1  single-cycle read strobe; back-to-back strobes are legal.
- bk_addr  in  17  word index; only [7:0] is decoded.
- bk_rtc_dout  out  16  read data.
- bk_rtc_ack  out  1  one-cycle pulse; bk_rtc_dout is valid in the same cycle.
- rtc_present  out  1  registered copy of RTC_inuse & enable.
- rtc_save_due  out  1  an autosave is requested.

Behaviour:
- Reset values: bk_rtc_dout=16'h0000, bk_rtc_ack=0, rtc_present=0, rtc_save_due=0. FSM=IDLE, snapshot registers=0, interval counter=0, prev_ts=0, first=1.
- The previous-timestamp register is loaded unconditionally on the first cycle after reset. That cycle does not count toward the interval.

FSM states: IDLE, ARMED.
- Read of addr 0 in any state: in the same cycle, snap_ts <= RTC_timestampOut and snap_st <= RTC_savedtimeOut; go to ARMED. The ack for this read already carries the newly captured word.
- Read of addr 4 in ARMED: complete the sequence. Go to IDLE, clear the interval counter, drop rtc_save_due in the cycle after the ack.
- Read of addr 4 in IDLE: acked with normal data. No counter clear (there is no valid snapshot).
- Reads of addr 1..3 in IDLE: served from the stale snapshot. State does not change.

Read data map (registered, 1-cycle latency):
- 0: snap_ts[15:0]
- 1: snap_ts[31:16]
- 2: snap_st[15:0]
- 3: snap_st[31:16]
- 4: 16'h0001 (commit marker)
- anything else: 16'hFFFF
- enable=0: every address returns 16'hFFFF. The ack still occurs and snapshot/FSM are not updated.
- A strobe in cycle N gives ack in N+1. Strobes in N and N+1 give acks in N+1 and N+2 with their own data (fully pipelined, no stall).

Interval counter:
- Each cycle, compare RTC_timestampOut with prev_ts.
- Equal to prev_ts+1: increment, saturating at SAVE_INTERVAL.
- Any other change (HPS timestamp reload, backward jump): counter unchanged.
- prev_ts is always updated.
- rtc_save_due = enable & RTC_inuse & (counter == SAVE_INTERVAL), registered.

Simultaneous events:
- Completing read (addr 4 in ARMED) in the same cycle as a +1 tick: the clear wins, counter=0.
- Addr 0 read in ARMED: re-snapshot (a restarted save sequence).

Other rules:
- Reset mid-sequence: an ack pending for the next cycle is suppressed and the FSM returns to IDLE.
- Arithmetic: 32-bit compare, wrap-around via modulo-2^32 +1 (FFFFFFFF→00000000 counts as a tick).

Decomposition:
- Shared package mbc_rtc_pkg:
  - word index constants RTC_W_TS_LO=0, RTC_W_TS_HI=1, RTC_W_ST_LO=2, RTC_W_ST_HI=3, RTC_W_COMMIT=4;
  - savedtime field offsets (sec 0, min 6, hours 12, days 17, overflow 27, halt 28);
  - RTC_COMMIT_MARKER=16'h0001.
- The mapper load path adopts the same package.
- One natural sub-module: rtc_interval_counter (tick detect, saturating count, clear).

Test Plan:
- Reset, then TS=0x12345678, ST=0x0ABCDEF0, reads 0,1,2,3,4 on consecutive cycles → acks on the next 5 cycles with 5678, 1234, DEF0, 0ABC, 0001; FSM returns to IDLE.
- Snapshot atomicity: read addr 0, change TS to 0x12345679 before the addr 1 read → addr 1 still returns 1234 and the addr 0 data was 5678; a second addr 0 read returns 5679.
- Interval, SAVE_INTERVAL=3 in the bench: RTC_inuse=1, TS steps +1 three times → rtc_save_due=1 one cycle after the third step. A jump of +100 instead → no increment. A full 0..4 sequence → due falls and counter=0.
- Wrap: TS 0xFFFFFFFF→0x00000000 → counts as one tick.
- Out-of-range and disable: addr 7 → FFFF with ack. enable=0, addr 0 → FFFF, snapshot unchanged, rtc_save_due=0.
- Reset mid-sequence: assert reset the cycle after an addr 2 strobe → no ack, dout=0000, FSM IDLE; a subsequent addr 4 read does not clear the counter.

Source files
------------

// File: rtl/mbc_rtc_pkg.sv
`default_nettype none
// ==== mbc_rtc_pkg : shared MBC3 RTC save-word layout and field offsets ==== rev 1.0 ====
package mbc_rtc_pkg;

  localparam logic [7:0] RTC_W_TS_LO  = 8'd0;
  localparam logic [7:0] RTC_W_TS_HI  = 8'd1;
  localparam logic [7:0] RTC_W_ST_LO  = 8'd2;
  localparam logic [7:0] RTC_W_ST_HI  = 8'd3;
  localparam logic [7:0] RTC_W_COMMIT = 8'd4;

  localparam int RTC_SEC_OFS      = 0;
  localparam int RTC_MIN_OFS      = 6;
  localparam int RTC_HOURS_OFS    = 12;
  localparam int RTC_DAYS_OFS     = 17;
  localparam int RTC_OVERFLOW_OFS = 27;
  localparam int RTC_HALT_OFS     = 28;

  localparam logic [15:0] RTC_COMMIT_MARKER = 16'h0001;
  localparam logic [15:0] RTC_UNMAPPED      = 16'hFFFF;

  typedef enum logic [0:0] {
    RTC_RD_IDLE  = 1'b0,
    RTC_RD_ARMED = 1'b1
  } rtc_rd_state_e;

endpackage
`default_nettype wire

// File: rtl/rtc_interval_counter.sv
`default_nettype none
// ==== rtc_interval_counter : counts +1 timestamp steps, saturating, clearable ==== rev 1.0 ====
module rtc_interval_counter #(
  parameter int SAVE_INTERVAL = 300,
  parameter int CNT_W         = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] timestamp,
  input  logic        clear,
  output logic        at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SAVE_INTERVAL);

  logic             first;
  logic [31:0]      prev_ts;
  logic [CNT_W-1:0] count;
  logic             tick;

  // Wrap-around FFFFFFFF->00000000 falls out of the modulo-2^32 add.
  assign tick     = ~first & (timestamp == prev_ts + 32'd1);
  assign at_limit = (count == LIMIT);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      first   <= 1'b1;
      prev_ts <= 32'd0;
      count   <= '0;
    end else begin
      first   <= 1'b0;
      prev_ts <= timestamp;
      if (clear)
        count <= '0;
      else if (tick && count != LIMIT)
        count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mbc_rtc_save_reader.sv
`default_nettype none
// ==== mbc_rtc_save_reader : atomic RTC snapshot, 5-word save readout, autosave request ==== rev 1.0 ====
module mbc_rtc_save_reader
  import mbc_rtc_pkg::*;
#(
  parameter int SAVE_INTERVAL = 300,
  parameter int CNT_W         = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic        RTC_inuse,
  input  logic [31:0] RTC_timestampOut,
  input  logic [31:0] RTC_savedtimeOut,
  input  logic        bk_rtc_rd,
  input  logic [16:0] bk_addr,
  output logic [15:0] bk_rtc_dout,
  output logic        bk_rtc_ack,
  output logic        rtc_present,
  output logic        rtc_save_due
);

  rtc_rd_state_e state_q, state_d;
  logic [31:0]   snap_ts, snap_st;
  logic          snap_load, cnt_clear, at_limit;
  logic [15:0]   dout_d, dout_q;
  logic          ack_q, present_q, due_q;
  logic [7:0]    addr;
  logic          unused_addr_hi;

  assign addr           = bk_addr[7:0];
  assign unused_addr_hi = ^bk_addr[16:8];

  rtc_interval_counter #(
    .SAVE_INTERVAL (SAVE_INTERVAL),
    .CNT_W         (CNT_W)
  ) u_interval (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .timestamp (RTC_timestampOut),
    .clear     (cnt_clear),
    .at_limit  (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    cnt_clear = 1'b0;
    dout_d    = RTC_UNMAPPED;
    if (enable) begin
      // Word 0 is served from the live input so its ack matches what gets captured.
      case (addr)
        RTC_W_TS_LO:  dout_d = RTC_timestampOut[15:0];
        RTC_W_TS_HI:  dout_d = snap_ts[31:16];
        RTC_W_ST_LO:  dout_d = snap_st[15:0];
        RTC_W_ST_HI:  dout_d = snap_st[31:16];
        RTC_W_COMMIT: dout_d = RTC_COMMIT_MARKER;
        default:      dout_d = RTC_UNMAPPED;
      endcase
      if (bk_rtc_rd) begin
        if (addr == RTC_W_TS_LO) begin
          snap_load = 1'b1;
          state_d   = RTC_RD_ARMED;
        end else if (addr == RTC_W_COMMIT && state_q == RTC_RD_ARMED) begin
          cnt_clear = 1'b1;
          state_d   = RTC_RD_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= RTC_RD_IDLE;
      snap_ts   <= 32'd0;
      snap_st   <= 32'd0;
      dout_q    <= 16'h0000;
      ack_q     <= 1'b0;
      present_q <= 1'b0;
      due_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (snap_load) begin
        snap_ts <= RTC_timestampOut;
        snap_st <= RTC_savedtimeOut;
      end
      ack_q <= bk_rtc_rd;
      if (bk_rtc_rd)
        dout_q <= dout_d;
      present_q <= enable & RTC_inuse;
      due_q     <= enable & RTC_inuse & at_limit;
    end
  end

  // Reset also masks an ack that was already registered for this cycle.
  assign bk_rtc_ack   = ack_q & ~reset;
  assign bk_rtc_dout  = reset ? 16'h0000 : dout_q;
  assign rtc_present  = present_q;
  assign rtc_save_due = due_q;

endmodule
`default_nettype wire

// File: tb/tb_mbc_rtc_save_reader.sv
`default_nettype none
// ==== tb_mbc_rtc_save_reader : scoreboard bench for the RTC save reader ==== rev 1.0 ====
module tb_mbc_rtc_save_reader;
  import mbc_rtc_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        RTC_inuse = 1'b0;
  logic [31:0] ts = 32'h12345678;
  logic [31:0] st = 32'h0ABCDEF0;
  logic        bk_rtc_rd = 1'b0;
  logic [16:0] bk_addr = 17'd0;
  logic [15:0] bk_rtc_dout;
  logic        bk_rtc_ack, rtc_present, rtc_save_due;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];

  mbc_rtc_save_reader #(.SAVE_INTERVAL(3), .CNT_W(16)) dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .enable           (enable),
    .RTC_inuse        (RTC_inuse),
    .RTC_timestampOut (ts),
    .RTC_savedtimeOut (st),
    .bk_rtc_rd        (bk_rtc_rd),
    .bk_addr          (bk_addr),
    .bk_rtc_dout      (bk_rtc_dout),
    .bk_rtc_ack       (bk_rtc_ack),
    .rtc_present      (rtc_present),
    .rtc_save_due     (rtc_save_due)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic rd(input logic [16:0] a, input logic [15:0] e);
    bk_rtc_rd = 1'b1;
    bk_addr   = a;
    exp_q.push_back(e);
    tick();
    bk_rtc_rd = 1'b0;
    bk_addr   = 17'd0;
  endtask

  task automatic step_ts(input logic [31:0] v);
    ts = v;
    tick();
  endtask

  // Monitor: every ack pops one expected word.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (bk_rtc_ack) begin
        if (exp_q.size() == 0) check("unexpected_ack", 32'(bk_rtc_ack), 32'd0);
        else check("rd_data", 32'(bk_rtc_dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tick(); tick(); tick();
    check("rst_dout", 32'(bk_rtc_dout), 32'h0);
    check("rst_ack", 32'(bk_rtc_ack), 32'h0);
    check("rst_present", 32'(rtc_present), 32'h0);
    check("rst_due", 32'(rtc_save_due), 32'h0);
    reset = 1'b0;
    tick();

    // Full 5-word readout
    rd(17'd0, 16'h5678); rd(17'd1, 16'h1234); rd(17'd2, 16'hDEF0);
    rd(17'd3, 16'h0ABC); rd(17'd4, 16'h0001);
    tick();
    check("fsm_idle_after_seq", 32'(dut.state_q), 32'(RTC_RD_IDLE));

    // Snapshot atomicity
    rd(17'd0, 16'h5678);
    ts = 32'h12345679;
    rd(17'd1, 16'h1234);
    rd(17'd0, 16'h5679);
    rd(17'd4, 16'h0001);

    // Interval: +100 jump ignored, three +1 steps reach the limit
    RTC_inuse = 1'b1;
    step_ts(32'h123456DD);
    step_ts(32'h123456DE);
    step_ts(32'h123456DF);
    tick();
    check("due_after_two_steps", 32'(rtc_save_due), 32'h0);
    check("present", 32'(rtc_present), 32'h1);
    step_ts(32'h123456E0);
    check("due_not_yet", 32'(rtc_save_due), 32'h0);
    tick();
    check("due_after_three_steps", 32'(rtc_save_due), 32'h1);
    step_ts(32'h123456E1);
    tick();
    check("due_saturated", 32'(rtc_save_due), 32'h1);
    rd(17'd0, 16'h56E1); rd(17'd1, 16'h1234); rd(17'd2, 16'hDEF0);
    rd(17'd3, 16'h0ABC); rd(17'd4, 16'h0001);
    check("due_at_commit_ack", 32'(rtc_save_due), 32'h1);
    tick();
    check("due_dropped", 32'(rtc_save_due), 32'h0);
    check("fsm_idle_after_commit", 32'(dut.state_q), 32'(RTC_RD_IDLE));

    // Wrap-around counts as a tick
    step_ts(32'hFFFFFFFE);
    step_ts(32'hFFFFFFFF);
    step_ts(32'h00000000);
    step_ts(32'h00000001);
    tick();
    check("wrap_due", 32'(rtc_save_due), 32'h1);

    // Out-of-range and upper address bits ignored
    rd(17'd7, 16'hFFFF);
    rd(17'h10003, 16'h0ABC);

    // Disabled: FFFF, no snapshot, no arming, due held low
    enable = 1'b0;
    tick(); tick();
    check("dis_due", 32'(rtc_save_due), 32'h0);
    check("dis_present", 32'(rtc_present), 32'h0);
    ts = 32'hAAAA5555;
    rd(17'd0, 16'hFFFF);
    rd(17'd2, 16'hFFFF);
    enable = 1'b1;
    tick(); tick();
    check("reen_due", 32'(rtc_save_due), 32'h1);
    rd(17'd1, 16'h1234);
    rd(17'd4, 16'h0001);
    tick(); tick();
    check("idle_commit_no_clear", 32'(rtc_save_due), 32'h1);

    // Reset mid-sequence
    rd(17'd0, 16'h5555);
    bk_rtc_rd = 1'b1;
    bk_addr   = 17'd2;
    tick();
    bk_rtc_rd = 1'b0;
    bk_addr   = 17'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_dout", 32'(bk_rtc_dout), 32'h0);
    check("midrst_ack", 32'(bk_rtc_ack), 32'h0);
    check("midrst_fsm", 32'(dut.state_q), 32'(RTC_RD_IDLE));
    tick();
    step_ts(32'hAAAA5556);
    step_ts(32'hAAAA5557);
    step_ts(32'hAAAA5558);
    tick();
    check("post_rst_due", 32'(rtc_save_due), 32'h1);
    rd(17'd4, 16'h0001);
    tick(); tick();
    check("post_rst_no_clear", 32'(rtc_save_due), 32'h1);

    tick(); tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
